button_debounce_array: RTL and testbench

Parametrised multi-channel push-button front end. It takes N raw, bouncy button inputs, synchronises and debounces each one against a shared sample-tick prescaler, and produces per-channel outputs:

- a clean level;
- single-cycle press, release and long-press pulses;
- a wrapping press counter.

It replaces the per-button divider/flip-flop chains and sits between board pins and the control FSMs.

---
 rtl/button_pkg.sv | 11 +
 rtl/button_channel.sv | 113 +++++++++++
 rtl/button_debounce_array.sv | 62 ++++++
 tb/tb_button_debounce_array.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared definitions for the push-button debounce front end.
package button_pkg;

    localparam int SYNC_STAGES = 2;

    // Bits needed to hold any value in 0..max_val (at least one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/button_channel.sv
// One debounce channel: synchroniser, stability counter, level, edge/long pulses
// and press counter, all advanced by the shared sample tick.
module button_channel
    import button_pkg::*;
#(
    parameter int STABLE_SAMPLES = 4,
    parameter int LONG_SAMPLES   = 200,
    parameter int CNT_W          = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             btn_raw,
    input  logic             cnt_clear,
    output logic             btn_level,
    output logic             press_pulse,
    output logic             release_pulse,
    output logic             long_pulse,
    output logic [CNT_W-1:0] press_count
);

    localparam int STAB_W = cnt_width(STABLE_SAMPLES - 1);
    localparam int HOLD_W = cnt_width(LONG_SAMPLES);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_SAMPLES - 1);
    localparam logic [STAB_W-1:0] STAB_ONE  = STAB_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_SAMPLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_SAMPLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_s;
    logic [STAB_W-1:0]      stab_cnt_r;
    logic [HOLD_W-1:0]      hold_cnt_r;
    logic                   level_r;
    logic                   press_r;
    logic                   release_r;
    logic                   long_r;
    logic [CNT_W-1:0]       count_r;

    assign sync_s = sync_r[SYNC_STAGES-1];

    // Two-flop synchroniser for the asynchronous pin.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], btn_raw};
        end
    end

    // Debounce: STABLE_SAMPLES consecutive disagreeing ticks flip the level;
    // the edge pulses are set on the same edge so they align with the new level.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stab_cnt_r <= '0;
            level_r    <= 1'b0;
            press_r    <= 1'b0;
            release_r  <= 1'b0;
        end else begin
            press_r   <= 1'b0;
            release_r <= 1'b0;
            if (tick) begin
                if (sync_s != level_r) begin
                    if (stab_cnt_r == STAB_LAST) begin
                        level_r    <= sync_s;
                        stab_cnt_r <= '0;
                        press_r    <= sync_s;
                        release_r  <= ~sync_s;
                    end else begin
                        stab_cnt_r <= stab_cnt_r + STAB_ONE;
                    end
                end else begin
                    stab_cnt_r <= '0;
                end
            end
        end
    end

    // Hold timer: saturates at LONG_SAMPLES, so the long pulse fires once per press.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hold_cnt_r <= '0;
            long_r     <= 1'b0;
        end else begin
            long_r <= 1'b0;
            if (!level_r) begin
                hold_cnt_r <= '0;
            end else if (tick && (hold_cnt_r != HOLD_MAX)) begin
                hold_cnt_r <= hold_cnt_r + HOLD_ONE;
                long_r     <= (hold_cnt_r == HOLD_LAST);
            end
        end
    end

    // Wrapping press counter; clear wins over a coincident press.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_r <= '0;
        end else if (cnt_clear) begin
            count_r <= '0;
        end else if (press_r) begin
            count_r <= count_r + CNT_ONE;
        end
    end

    assign btn_level     = level_r;
    assign press_pulse   = press_r;
    assign release_pulse = release_r;
    assign long_pulse    = long_r;
    assign press_count   = count_r;

endmodule

// File: rtl/button_debounce_array.sv
// Multi-channel button front end: one shared sample-tick prescaler feeding
// N_BUTTONS independent debounce channels.
module button_debounce_array
    import button_pkg::*;
#(
    parameter int N_BUTTONS      = 4,
    parameter int SAMPLE_DIV     = 50000,
    parameter int STABLE_SAMPLES = 4,
    parameter int LONG_SAMPLES   = 200,
    parameter int CNT_W          = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_BUTTONS-1:0]       btn_raw,
    input  logic [N_BUTTONS-1:0]       cnt_clear,
    output logic [N_BUTTONS-1:0]       btn_level,
    output logic [N_BUTTONS-1:0]       press_pulse,
    output logic [N_BUTTONS-1:0]       release_pulse,
    output logic [N_BUTTONS-1:0]       long_pulse,
    output logic [N_BUTTONS*CNT_W-1:0] press_count
);

    localparam int PRESC_W = cnt_width(SAMPLE_DIV - 1);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SAMPLE_DIV - 1);
    localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);

    logic [PRESC_W-1:0] presc_r;
    logic               tick_s;

    assign tick_s = (presc_r == PRESC_LAST);

    // Free-running prescaler wrapping at SAMPLE_DIV-1.
    always_ff @(posedge clk) begin
        if (!reset) begin
            presc_r <= '0;
        end else if (tick_s) begin
            presc_r <= '0;
        end else begin
            presc_r <= presc_r + PRESC_ONE;
        end
    end

    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_chan
        button_channel #(
            .STABLE_SAMPLES (STABLE_SAMPLES),
            .LONG_SAMPLES   (LONG_SAMPLES),
            .CNT_W          (CNT_W)
        ) u_chan (
            .clk           (clk),
            .reset         (reset),
            .tick          (tick_s),
            .btn_raw       (btn_raw[i]),
            .cnt_clear     (cnt_clear[i]),
            .btn_level     (btn_level[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i]),
            .long_pulse    (long_pulse[i]),
            .press_count   (press_count[i*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_button_debounce_array.sv
// Directed bench for button_debounce_array with a fast prescaler (2 channels).
module tb_button_debounce_array;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] btn_raw;
    logic [1:0] cnt_clear;
    logic [1:0] btn_level;
    logic [1:0] press_pulse;
    logic [1:0] release_pulse;
    logic [1:0] long_pulse;
    logic [3:0] press_count;

    int n_checks = 0;
    int n_fail   = 0;
    int n_press [2] = '{0, 0};
    int n_rel   [2] = '{0, 0};
    int n_long  [2] = '{0, 0};
    int n_hi    [2] = '{0, 0};
    int n_both  = 0;

    button_debounce_array #(
        .N_BUTTONS      (2),
        .SAMPLE_DIV     (4),
        .STABLE_SAMPLES (3),
        .LONG_SAMPLES   (8),
        .CNT_W          (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_raw       (btn_raw),
        .cnt_clear     (cnt_clear),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .press_count   (press_count)
    );

    always #5 clk = ~clk;

    // Pulse/level tallies sampled away from the active edge.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (press_pulse[i] === 1'b1)   n_press[i]++;
            if (release_pulse[i] === 1'b1) n_rel[i]++;
            if (long_pulse[i] === 1'b1)    n_long[i]++;
            if (btn_level[i] === 1'b1)     n_hi[i]++;
            if (press_pulse[i] === 1'b1 && release_pulse[i] === 1'b1) n_both++;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Waits up to 30 cycles for btn_level[ch]==val; lat=-1 on timeout.
    task automatic wait_level(input int ch, input logic val, output int lat);
        lat = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (btn_level[ch] === val) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic press_ch0(input bit clr_on_pulse);
        int lat;
        btn_raw[0] = 1'b1;
        wait_level(0, 1'b1, lat);
        check_val("press_rise_found", 32'(lat > 0), 32'd1);
        check_val("press_pulse_on_rise", 32'(press_pulse[0]), 32'd1);
        if (clr_on_pulse) cnt_clear[0] = 1'b1;
        @(negedge clk);
        cnt_clear[0] = 1'b0;
        btn_raw[0] = 1'b0;
        wait_level(0, 1'b0, lat);
        check_val("press_fall_found", 32'(lat > 0), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int lat, rise_c, long_c, p0, r0, h0, l1, r1, l0;
        logic [1:0] exp_cnt [5];
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        // 1. Reset held with both buttons pressed
        reset = 1'b0;
        btn_raw = 2'b11;
        cnt_clear = 2'b00;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_val("reset_outputs",
                      32'({btn_level, press_pulse, release_pulse, long_pulse, press_count}), 32'd0);
        end
        reset = 1'b1;
        btn_raw = 2'b00;
        repeat (5) @(negedge clk);
        check_val("no_pulse_after_reset", 32'(n_press[0] + n_press[1] + n_rel[0] + n_rel[1]), 32'd0);

        // 2. Clean press on channel 0
        btn_raw[0] = 1'b1;
        wait_level(0, 1'b1, lat);
        check_val("press_latency_11_14", 32'(lat >= 11 && lat <= 14), 32'd1);
        check_val("press_pulse0_high", 32'(press_pulse[0]), 32'd1);
        check_val("release_pulse0_low", 32'(release_pulse[0]), 32'd0);
        @(negedge clk);
        check_val("press_pulse0_one_cycle", 32'(press_pulse[0]), 32'd0);
        check_val("press_count0_one", 32'(press_count[1:0]), 32'd1);
        check_val("ch1_level_idle", 32'(btn_level[1]), 32'd0);
        check_val("ch1_count_idle", 32'(press_count[3:2]), 32'd0);
        check_val("press_tally0", 32'(n_press[0]), 32'd1);
        repeat (5) @(negedge clk);
        btn_raw[0] = 1'b0;
        wait_level(0, 1'b0, lat);
        check_val("release_latency_11_14", 32'(lat >= 11 && lat <= 14), 32'd1);
        check_val("release_pulse0_high", 32'(release_pulse[0]), 32'd1);
        repeat (3) @(negedge clk);

        // 3. Bounce never qualifies
        p0 = n_press[0]; r0 = n_rel[0]; h0 = n_hi[0];
        for (int k = 0; k < 8; k++) begin
            btn_raw[0] = ~btn_raw[0];
            repeat (5) @(negedge clk);
        end
        btn_raw[0] = 1'b0;
        repeat (20) @(negedge clk);
        check_val("bounce_level_never_high", 32'(n_hi[0] - h0), 32'd0);
        check_val("bounce_no_press", 32'(n_press[0] - p0), 32'd0);
        check_val("bounce_no_release", 32'(n_rel[0] - r0), 32'd0);

        // 4. Long press on channel 1
        l1 = n_long[1]; r1 = n_rel[1];
        rise_c = -1; long_c = -1;
        btn_raw[1] = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (btn_level[1] === 1'b1 && rise_c < 0) rise_c = c;
            if (long_pulse[1] === 1'b1 && long_c < 0) long_c = c;
        end
        check_val("long_rise_11_14", 32'(rise_c >= 11 && rise_c <= 14), 32'd1);
        check_val("long_delay_28_36", 32'(rise_c > 0 && (long_c - rise_c) >= 28 && (long_c - rise_c) <= 36), 32'd1);
        check_val("long_fires_once", 32'(n_long[1] - l1), 32'd1);
        check_val("ch1_count_one", 32'(press_count[3:2]), 32'd1);
        btn_raw[1] = 1'b0;
        wait_level(1, 1'b0, lat);
        check_val("long_release_9_14", 32'(lat >= 9 && lat <= 14), 32'd1);
        check_val("release_pulse1_high", 32'(release_pulse[1]), 32'd1);
        repeat (3) @(negedge clk);
        check_val("release1_once", 32'(n_rel[1] - r1), 32'd1);
        check_val("long_no_refire", 32'(n_long[1] - l1), 32'd1);

        // 5. Counter wrap then clear coincident with a press pulse
        cnt_clear[0] = 1'b1;
        @(negedge clk);
        cnt_clear[0] = 1'b0;
        check_val("count0_cleared", 32'(press_count[1:0]), 32'd0);
        for (int k = 0; k < 5; k++) begin
            press_ch0(1'b0);
            check_val("count0_wrap_seq", 32'(press_count[1:0]), 32'(exp_cnt[k]));
        end
        press_ch0(1'b1);
        check_val("count0_clear_priority", 32'(press_count[1:0]), 32'd0);

        // 6. Reset in the middle of a held press
        btn_raw[0] = 1'b1;
        wait_level(0, 1'b1, lat);
        check_val("midpress_rise_found", 32'(lat > 0), 32'd1);
        repeat (20) @(negedge clk);
        r0 = n_rel[0]; l0 = n_long[0];
        check_val("midpress_level_high", 32'(btn_level[0]), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check_val("midpress_level_cleared", 32'(btn_level[0]), 32'd0);
        check_val("midpress_no_release", 32'(release_pulse[0]), 32'd0);
        check_val("midpress_no_long", 32'(long_pulse[0]), 32'd0);
        btn_raw[0] = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        check_val("midpress_no_release_later", 32'(n_rel[0] - r0), 32'd0);
        check_val("midpress_no_long_later", 32'(n_long[0] - l0), 32'd0);
        check_val("midpress_counts_zero", 32'(press_count), 32'd0);
        check_val("never_press_and_release", 32'(n_both), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
